// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the writeback-port scheduler.
// wb_pkt_t is the full writeback uop payload carried through the skid queues.
package wb_sched_pkg;

   localparam int unsigned BR_W  = 12;
   localparam int unsigned PKT_W = 119;

   typedef struct packed {
      logic [6:0]  uopc;
      logic [11:0] br_mask;
      logic [5:0]  rob_idx;
      logic [3:0]  stq_idx;
      logic [6:0]  pdst;
      logic        is_amo;
      logic        uses_stq;
      logic [1:0]  dst_rtype;
      logic        fp_val;
      logic [64:0] data;
      logic        predicated;
      logic        fflags_valid;
      logic [5:0]  fflags_rob_idx;
      logic [4:0]  fflags;
   } wb_pkt_t;

endpackage

// File: rtl/wb_kill_queue.sv
// Skid FIFO for one writeback requester.
// Tracks branch masks per slot and drops killed entries at the head.
module wb_kill_queue
   import wb_sched_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enq_valid,
   output logic            enq_ready,
   input  wb_pkt_t         enq_bits,
   input  logic [BR_W-1:0] resolve_mask,
   input  logic [BR_W-1:0] mispredict_mask,
   input  logic            flush,
   output logic            head_cand,
   output wb_pkt_t         head_bits,
   input  logic            deq
);

   localparam int unsigned PtrW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

   wb_pkt_t                slot_q [NUM_ENTRIES];
   wb_pkt_t                slot_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] live_q, live_d;
   logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]        count_q, count_d;

   wb_pkt_t head_pkt, enq_pkt;
   logic    head_occ, head_live, head_hit, silent_pop, do_enq, do_deq, enq_live;

   assign head_pkt   = slot_q[head_q];
   assign head_occ   = (count_q != '0);
   assign head_live  = live_q[head_q];
   assign head_hit   = |(head_pkt.br_mask & mispredict_mask);
   assign head_cand  = head_occ & head_live & ~head_hit;
   // Dead heads drain one per cycle regardless of downstream backpressure.
   assign silent_pop = head_occ & ~head_live;
   assign enq_ready  = (count_q < CntW'(NUM_ENTRIES));
   assign do_enq     = enq_valid & enq_ready & ~flush;
   assign do_deq     = silent_pop | (deq & head_cand);
   assign enq_live   = ~|(enq_bits.br_mask & mispredict_mask);

   always_comb begin
      head_bits         = head_pkt;
      head_bits.br_mask = head_pkt.br_mask & ~resolve_mask;
      enq_pkt           = enq_bits;
      enq_pkt.br_mask   = enq_bits.br_mask & ~resolve_mask;
   end

   always_comb begin
      slot_d  = slot_q;
      live_d  = live_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         live_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            slot_d[i].br_mask = slot_q[i].br_mask & ~resolve_mask;
            if (|(slot_d[i].br_mask & mispredict_mask)) live_d[i] = 1'b0;
         end
         if (do_enq) begin
            slot_d[tail_q] = enq_pkt;
            live_d[tail_q] = enq_live;
            tail_d         = tail_q + PtrW'(1);
         end
         if (do_deq) head_d = head_q + PtrW'(1);
         case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) slot_q[i] <= '0;
         live_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         slot_q  <= slot_d;
         live_q  <= live_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_port_sched.sv
// Shares one register-file writeback port between two response streams.
// Input 0 wins by default; input 1 is forced through after MAX_WAIT lost cycles.
module wb_port_sched #(
   parameter int unsigned NUM_ENTRIES = 2,
   parameter int unsigned MAX_WAIT    = 4,
   parameter int unsigned BR_W        = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_in_0_valid,
   output logic                  io_in_0_ready,
   input  wb_sched_pkg::wb_pkt_t io_in_0_bits,
   input  logic                  io_in_1_valid,
   output logic                  io_in_1_ready,
   input  wb_sched_pkg::wb_pkt_t io_in_1_bits,
   input  logic [BR_W-1:0]       io_brupdate_resolve_mask,
   input  logic [BR_W-1:0]       io_brupdate_mispredict_mask,
   input  logic                  io_flush,
   output logic                  io_out_valid,
   input  logic                  io_out_ready,
   output wb_sched_pkg::wb_pkt_t io_out_bits,
   output logic                  io_starve_grant
);

   import wb_sched_pkg::*;

   wb_pkt_t    bits0, bits1;
   logic       cand0, cand1, starve, grant1, fire, deq0, deq1;
   logic [3:0] wait_q, wait_d;

   wb_kill_queue #(
      .NUM_ENTRIES(NUM_ENTRIES)
   ) u_q0 (
      .clock          (clock),
      .reset          (reset),
      .enq_valid      (io_in_0_valid),
      .enq_ready      (io_in_0_ready),
      .enq_bits       (io_in_0_bits),
      .resolve_mask   (io_brupdate_resolve_mask),
      .mispredict_mask(io_brupdate_mispredict_mask),
      .flush          (io_flush),
      .head_cand      (cand0),
      .head_bits      (bits0),
      .deq            (deq0)
   );

   wb_kill_queue #(
      .NUM_ENTRIES(NUM_ENTRIES)
   ) u_q1 (
      .clock          (clock),
      .reset          (reset),
      .enq_valid      (io_in_1_valid),
      .enq_ready      (io_in_1_ready),
      .enq_bits       (io_in_1_bits),
      .resolve_mask   (io_brupdate_resolve_mask),
      .mispredict_mask(io_brupdate_mispredict_mask),
      .flush          (io_flush),
      .head_cand      (cand1),
      .head_bits      (bits1),
      .deq            (deq1)
   );

   assign starve          = (wait_q == 4'(MAX_WAIT)) & cand1;
   assign grant1          = starve | (~cand0 & cand1);
   assign io_out_valid    = (cand0 | cand1) & ~io_flush;
   assign io_out_bits     = grant1 ? bits1 : bits0;
   assign io_starve_grant = starve & ~io_flush;
   assign fire            = io_out_valid & io_out_ready;
   assign deq0            = fire & ~grant1;
   assign deq1            = fire & grant1;

   always_comb begin
      wait_d = wait_q;
      if (io_flush || !cand1 || deq1) begin
         wait_d = '0;
      end else if (wait_q < 4'(MAX_WAIT)) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_d;
   end

endmodule
